// File: rtl/wb2axi4l_bridge.sv
// wb2axi4l_bridge
//   Wishbone-classic slave to AXI4-Lite master bridge. Each Wishbone cycle
//   becomes exactly one AXI4-Lite read or write; the AXI response comes back
//   as a one-cycle wb_ack_o (OKAY/EXOKAY) or wb_err_o (SLVERR/DECERR) pulse.
//   Only one transaction is in flight at a time.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   wb_adr_i..wb_stb_i    Wishbone slave request (address, data, sel, we, cyc, stb)
//   wb_dat_o              registered read data, held until the next read completes
//   wb_ack_o / wb_err_o   termination pulses, one cycle each
//   m_axi_aw* / m_axi_w*  AXI4-Lite write address / write data channels
//   m_axi_b*              AXI4-Lite write response channel
//   m_axi_ar* / m_axi_r*  AXI4-Lite read address / read data channels
module wb2axi4l_bridge #(
  parameter int unsigned ADRWIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADRWIDTH-1:0] wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [ADRWIDTH-1:0] m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [31:0]         m_axi_wdata,
  output logic [3:0]          m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADRWIDTH-1:0] m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [31:0]         m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_TERM
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADRWIDTH-1:0] r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [31:0]         r_rdata;
  logic [1:0]          r_resp;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_arvalid;
  logic                r_bready;
  logic                r_rready;
  logic                r_abort;

  logic w_req;
  logic w_aw_done;
  logic w_w_done;
  logic w_resp_err;

  assign w_req = wb_cyc_i & wb_stb_i;

  // Each write channel's valid only ever falls after its own handshake, so
  // a low valid inside WR_REQ means that channel has already completed.
  assign w_aw_done = ~r_awvalid | m_axi_awready;
  assign w_w_done  = ~r_wvalid  | m_axi_wready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_req) w_state_nxt = wb_we_i ? S_WR_REQ : S_RD_REQ;
      S_WR_REQ:  if (w_aw_done && w_w_done) w_state_nxt = S_WR_RESP;
      S_WR_RESP: if (m_axi_bvalid) w_state_nxt = S_TERM;
      S_RD_REQ:  if (m_axi_arready) w_state_nxt = S_RD_RESP;
      S_RD_RESP: if (m_axi_rvalid) w_state_nxt = S_TERM;
      S_TERM:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_resp    <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_bready  <= 1'b0;
      r_rready  <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr    <= wb_adr_i;
            r_wdata   <= wb_dat_i;
            r_wstrb   <= wb_sel_i;
            r_awvalid <= wb_we_i;
            r_wvalid  <= wb_we_i;
            r_arvalid <= ~wb_we_i;
          end
        end
        S_WR_REQ: begin
          if (m_axi_awready) r_awvalid <= 1'b0;
          if (m_axi_wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) r_bready <= 1'b1;
        end
        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            r_resp   <= m_axi_bresp;
            r_bready <= 1'b0;
          end
        end
        S_RD_REQ: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        S_RD_RESP: begin
          if (m_axi_rvalid) begin
            r_rdata  <= m_axi_rdata;
            r_resp   <= m_axi_rresp;
            r_rready <= 1'b0;
          end
        end
        S_TERM: r_abort <= 1'b0;
        default: ;
      endcase
      // A dropped cyc cannot cancel the AXI side; remember it so the
      // eventual termination is swallowed instead of reaching a new cycle.
      if ((r_state != S_IDLE) && (r_state != S_TERM) && !wb_cyc_i) begin
        r_abort <= 1'b1;
      end
    end
  end

  always_comb begin
    case (r_resp)
      2'b00, 2'b01: w_resp_err = 1'b0;
      default:      w_resp_err = 1'b1;
    endcase
  end

  assign wb_ack_o = (r_state == S_TERM) & ~r_abort & ~w_resp_err;
  assign wb_err_o = (r_state == S_TERM) & ~r_abort &  w_resp_err;
  assign wb_dat_o = r_rdata;

  assign m_axi_awaddr  = r_addr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_wb2axi4l_bridge.sv
// Self-checking bench for wb2axi4l_bridge: a Wishbone master driven from
// scenario tasks and a delay-configurable AXI4-Lite slave model.
module tb_wb2axi4l_bridge;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
  logic        m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
  logic [31:0] m_axi_rdata = '0;

  always #5 clk = ~clk;

  wb2axi4l_bridge #(.ADRWIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int unsigned cycle_no = 0;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    bit          is_read;
    bit          exp_err;
    logic [31:0] exp_dat;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
  } sb_t;
  sb_t sb_q[$];

  // Slave configuration (written by the scenario tasks only).
  int unsigned cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0, cfg_b_dly = 0, cfg_r_dly = 0;
  logic [1:0]  cfg_bresp = '0, cfg_rresp = '0;
  logic [31:0] cfg_rdata = '0;

  // Slave observations (written by the slave process only).
  int unsigned aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0, viol = 0;
  int unsigned aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
  logic [31:0] seen_awaddr = '0, seen_wdata = '0, seen_araddr = '0;
  logic [3:0]  seen_wstrb = '0;
  logic [2:0]  seen_awprot = '0, seen_arprot = '0;

  // AXI4-Lite slave: decides ready/valid at the negedge so each handshake
  // lands on the following posedge; flags any valid/payload change while stalled.
  initial begin
    int unsigned aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit got_aw, got_w, got_ar, b_clr, r_clr, aw_pend, w_pend, ar_pend;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    got_aw = 0; got_w = 0; got_ar = 0; b_clr = 0; r_clr = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0;
    p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_wstrb = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        got_aw = 0; got_w = 0; got_ar = 0; b_clr = 0; r_clr = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
      end else begin
        if (aw_pend && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr)) viol++;
        if (w_pend && (!m_axi_wvalid || m_axi_wdata !== p_wdata || m_axi_wstrb !== p_wstrb)) viol++;
        if (ar_pend && (!m_axi_arvalid || m_axi_araddr !== p_araddr)) viol++;
        if (got_aw && got_w && !m_axi_bvalid) begin
          if (b_cnt >= cfg_b_dly) begin m_axi_bvalid = 1; m_axi_bresp = cfg_bresp; end
          else b_cnt++;
        end
        if (m_axi_bvalid && m_axi_bready) begin
          b_hs++; got_aw = 0; got_w = 0; b_cnt = 0; b_clr = 1;
        end
        if (got_ar && !m_axi_rvalid) begin
          if (r_cnt >= cfg_r_dly) begin
            m_axi_rvalid = 1; m_axi_rdata = cfg_rdata; m_axi_rresp = cfg_rresp;
          end else r_cnt++;
        end
        if (m_axi_rvalid && m_axi_rready) begin
          r_hs++; got_ar = 0; r_cnt = 0; r_clr = 1;
        end
        m_axi_awready = m_axi_awvalid && (aw_cnt >= cfg_aw_dly);
        if (m_axi_awvalid && !m_axi_awready) aw_cnt++;
        if (m_axi_awvalid && m_axi_awready) begin
          aw_hs++; aw_cyc = cycle_no; seen_awaddr = m_axi_awaddr; seen_awprot = m_axi_awprot;
          got_aw = 1; aw_cnt = 0;
        end
        aw_pend = m_axi_awvalid && !m_axi_awready; p_awaddr = m_axi_awaddr;
        m_axi_wready = m_axi_wvalid && (w_cnt >= cfg_w_dly);
        if (m_axi_wvalid && !m_axi_wready) w_cnt++;
        if (m_axi_wvalid && m_axi_wready) begin
          w_hs++; w_cyc = cycle_no; seen_wdata = m_axi_wdata; seen_wstrb = m_axi_wstrb;
          got_w = 1; w_cnt = 0;
        end
        w_pend = m_axi_wvalid && !m_axi_wready; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
        m_axi_arready = m_axi_arvalid && (ar_cnt >= cfg_ar_dly);
        if (m_axi_arvalid && !m_axi_arready) ar_cnt++;
        if (m_axi_arvalid && m_axi_arready) begin
          ar_hs++; ar_cyc = cycle_no; seen_araddr = m_axi_araddr; seen_arprot = m_axi_arprot;
          got_ar = 1; ar_cnt = 0;
        end
        ar_pend = m_axi_arvalid && !m_axi_arready; p_araddr = m_axi_araddr;
      end
      @(posedge clk); #1;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      if (b_clr) begin m_axi_bvalid = 0; b_clr = 0; end
      if (r_clr) begin m_axi_rvalid = 0; r_clr = 0; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wb_idle();
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
  endtask

  task automatic wb_start(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input bit exp_err, input logic [31:0] exp_dat,
                          output int unsigned s0);
    sb_t it;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1; wb_stb_i = 1;
    s0 = cycle_no;
    it.is_read = !we; it.exp_err = exp_err; it.exp_dat = exp_dat;
    it.adr = adr; it.wdat = dat; it.sel = sel;
    sb_q.push_back(it);
  endtask

  // Waits (bounded) for ack or err; lat counts cycles since the request was driven.
  task automatic wait_term(output int unsigned lat, output bit timeout);
    bit done = 0;
    lat = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      lat++;
      if (wb_ack_o || wb_err_o) done = 1;
    end
    timeout = !done;
  endtask

  task automatic test_reset();
    rst_i = 1; wb_idle();
    repeat (3) tick();
    n_checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin n_errors++; $display("FAIL rst_valids: got %b exp 00000", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}); end
    n_checks++; if ({wb_ack_o, wb_err_o} !== 2'b00) begin n_errors++; $display("FAIL rst_ackerr: got %b exp 00", {wb_ack_o, wb_err_o}); end
    n_checks++; if (wb_dat_o !== 32'h0) begin n_errors++; $display("FAIL rst_dat: got %h exp 0", wb_dat_o); end
    n_checks++; if ({m_axi_awaddr, m_axi_araddr} !== 64'h0) begin n_errors++; $display("FAIL rst_addr: got %h/%h exp 0", m_axi_awaddr, m_axi_araddr); end
    n_checks++; if ({m_axi_wdata, m_axi_wstrb} !== 36'h0) begin n_errors++; $display("FAIL rst_wpay: got %h/%h exp 0", m_axi_wdata, m_axi_wstrb); end
    rst_i = 0;
    tick();
  endtask

  task automatic test_write_zero_wait();
    int unsigned s0, lat; bit to; sb_t it;
    int unsigned aw0 = aw_hs, w0 = w_hs;
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_bresp = 2'b00;
    wb_start(1, 32'h40, 32'hDEADBEEF, 4'hF, 0, 32'h0, s0);
    wait_term(lat, to);
    it = sb_q.pop_front();
    n_checks++; if (to) begin n_errors++; $display("FAIL wz_timeout: no termination within 40 cycles"); end
    n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL wz_latency: got %0d exp 3", lat); end
    n_checks++; if ({wb_ack_o, wb_err_o} !== {!it.exp_err, it.exp_err}) begin n_errors++; $display("FAIL wz_ackerr: got %b exp %b", {wb_ack_o, wb_err_o}, {!it.exp_err, it.exp_err}); end
    n_checks++; if (aw_cyc - s0 !== 1 || w_cyc - s0 !== 1) begin n_errors++; $display("FAIL wz_hs_cycle: got aw %0d w %0d exp 1 1", aw_cyc - s0, w_cyc - s0); end
    n_checks++; if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1) begin n_errors++; $display("FAIL wz_hs_count: got aw %0d w %0d exp 1 1", aw_hs - aw0, w_hs - w0); end
    n_checks++; if ({seen_awaddr, seen_wdata, seen_wstrb, seen_awprot} !== {it.adr, it.wdat, it.sel, 3'b000}) begin n_errors++; $display("FAIL wz_payload: got %h %h %h %b exp %h %h %h 000", seen_awaddr, seen_wdata, seen_wstrb, seen_awprot, it.adr, it.wdat, it.sel); end
    wb_idle();
    tick();
    n_checks++; if ({wb_ack_o, wb_err_o} !== 2'b00) begin n_errors++; $display("FAIL wz_pulse: got %b exp 00", {wb_ack_o, wb_err_o}); end
  endtask

  task automatic test_write_skewed();
    int unsigned s0, lat; bit to; sb_t it;
    int unsigned aw0 = aw_hs, w0 = w_hs, b0 = b_hs, v0 = viol;
    cfg_aw_dly = 3; cfg_w_dly = 0; cfg_b_dly = 2; cfg_bresp = 2'b00;
    wb_start(1, 32'h100, 32'h0BADF00D, 4'h3, 0, 32'h0, s0);
    wait_term(lat, to);
    it = sb_q.pop_front();
    n_checks++; if (to || lat !== 8) begin n_errors++; $display("FAIL ws_latency: got %0d (timeout %0b) exp 8", lat, to); end
    n_checks++; if (wb_ack_o !== !it.exp_err) begin n_errors++; $display("FAIL ws_ack: got %b exp %b", wb_ack_o, !it.exp_err); end
    n_checks++; if (w_cyc - s0 !== 1 || aw_cyc - s0 !== 4) begin n_errors++; $display("FAIL ws_hs_cycle: got w %0d aw %0d exp 1 4", w_cyc - s0, aw_cyc - s0); end
    n_checks++; if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1 || b_hs - b0 !== 1) begin n_errors++; $display("FAIL ws_hs_count: got aw %0d w %0d b %0d exp 1 1 1", aw_hs - aw0, w_hs - w0, b_hs - b0); end
    n_checks++; if (viol - v0 !== 0) begin n_errors++; $display("FAIL ws_stability: got %0d violations exp 0", viol - v0); end
    n_checks++; if ({seen_awaddr, seen_wdata, seen_wstrb} !== {it.adr, it.wdat, it.sel}) begin n_errors++; $display("FAIL ws_payload: got %h %h %h exp %h %h %h", seen_awaddr, seen_wdata, seen_wstrb, it.adr, it.wdat, it.sel); end
    wb_idle();
    tick();
  endtask

  task automatic test_read();
    int unsigned s0, lat; bit to; sb_t it;
    cfg_ar_dly = 2; cfg_r_dly = 0; cfg_rdata = 32'h12345678; cfg_rresp = 2'b00;
    wb_start(0, 32'h44, 32'h0, 4'hF, 0, 32'h12345678, s0);
    wait_term(lat, to);
    it = sb_q.pop_front();
    n_checks++; if (to || lat !== 5) begin n_errors++; $display("FAIL rd_latency: got %0d (timeout %0b) exp 5", lat, to); end
    n_checks++; if ({wb_ack_o, wb_err_o} !== {!it.exp_err, it.exp_err}) begin n_errors++; $display("FAIL rd_ackerr: got %b exp %b", {wb_ack_o, wb_err_o}, {!it.exp_err, it.exp_err}); end
    n_checks++; if (wb_dat_o !== it.exp_dat) begin n_errors++; $display("FAIL rd_data: got %h exp %h", wb_dat_o, it.exp_dat); end
    n_checks++; if ({seen_araddr, seen_arprot} !== {it.adr, 3'b000}) begin n_errors++; $display("FAIL rd_araddr: got %h %b exp %h 000", seen_araddr, seen_arprot, it.adr); end
    wb_idle();
    tick();
    cfg_ar_dly = 0; cfg_aw_dly = 0; cfg_b_dly = 0;
    wb_start(1, 32'h48, 32'hFFFF0000, 4'hC, 0, 32'h0, s0);
    wait_term(lat, to);
    it = sb_q.pop_front();
    n_checks++; if (to || wb_ack_o !== !it.exp_err) begin n_errors++; $display("FAIL rd_follow_wr_ack: got %b (timeout %0b) exp %b", wb_ack_o, to, !it.exp_err); end
    wb_idle();
    repeat (3) tick();
    n_checks++; if (wb_dat_o !== 32'h12345678) begin n_errors++; $display("FAIL rd_hold: got %h exp 12345678", wb_dat_o); end
  endtask

  task automatic test_error();
    int unsigned s0, lat; bit to; sb_t it;
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_bresp = 2'b10;
    wb_start(1, 32'h50, 32'h00000001, 4'h1, 1, 32'h0, s0);
    wait_term(lat, to);
    it = sb_q.pop_front();
    n_checks++; if (to || {wb_ack_o, wb_err_o} !== {!it.exp_err, it.exp_err} || lat !== 3) begin n_errors++; $display("FAIL err_wr_slverr: got ack/err %b lat %0d exp %b lat 3", {wb_ack_o, wb_err_o}, lat, {!it.exp_err, it.exp_err}); end
    wb_idle(); tick();
    cfg_ar_dly = 0; cfg_r_dly = 0; cfg_rresp = 2'b11; cfg_rdata = 32'hA5A5A5A5;
    wb_start(0, 32'h54, 32'h0, 4'hF, 1, 32'hA5A5A5A5, s0);
    wait_term(lat, to);
    it = sb_q.pop_front();
    n_checks++; if (to || {wb_ack_o, wb_err_o} !== {!it.exp_err, it.exp_err}) begin n_errors++; $display("FAIL err_rd_decerr: got %b exp %b", {wb_ack_o, wb_err_o}, {!it.exp_err, it.exp_err}); end
    n_checks++; if (wb_dat_o !== it.exp_dat) begin n_errors++; $display("FAIL err_rd_data: got %h exp %h", wb_dat_o, it.exp_dat); end
    wb_idle(); tick();
    n_checks++; if ({wb_ack_o, wb_err_o} !== 2'b00) begin n_errors++; $display("FAIL err_pulse: got %b exp 00", {wb_ack_o, wb_err_o}); end
    cfg_bresp = 2'b01;
    wb_start(1, 32'h58, 32'h2, 4'h2, 0, 32'h0, s0);
    wait_term(lat, to);
    it = sb_q.pop_front();
    n_checks++; if (to || {wb_ack_o, wb_err_o} !== {!it.exp_err, it.exp_err}) begin n_errors++; $display("FAIL err_exokay: got %b exp %b", {wb_ack_o, wb_err_o}, {!it.exp_err, it.exp_err}); end
    wb_idle(); tick();
    cfg_bresp = 2'b00; cfg_rresp = 2'b00;
  endtask

  task automatic test_abort();
    int unsigned s0, lat; bit to; sb_t it;
    int unsigned ar0 = ar_hs, r0 = r_hs, v0 = viol, n_ack = 0, n_err = 0;
    cfg_ar_dly = 3; cfg_r_dly = 0; cfg_rdata = 32'hCAFEF00D; cfg_rresp = 2'b00;
    wb_adr_i = 32'h80; wb_we_i = 0; wb_sel_i = 4'hF; wb_cyc_i = 1; wb_stb_i = 1;
    tick();
    n_checks++; if (m_axi_arvalid !== 1'b1) begin n_errors++; $display("FAIL ab_arvalid: got %b exp 1", m_axi_arvalid); end
    wb_idle();
    for (int i = 0; i < 15; i++) begin
      tick();
      if (wb_ack_o) n_ack++;
      if (wb_err_o) n_err++;
    end
    n_checks++; if (n_ack !== 0 || n_err !== 0) begin n_errors++; $display("FAIL ab_suppress: got ack %0d err %0d exp 0 0", n_ack, n_err); end
    n_checks++; if (ar_hs - ar0 !== 1 || r_hs - r0 !== 1) begin n_errors++; $display("FAIL ab_completes: got ar %0d r %0d exp 1 1", ar_hs - ar0, r_hs - r0); end
    n_checks++; if (viol - v0 !== 0) begin n_errors++; $display("FAIL ab_stability: got %0d violations exp 0", viol - v0); end
    cfg_ar_dly = 0; cfg_rdata = 32'h0F0F0F0F;
    wb_start(0, 32'h8, 32'h0, 4'hF, 0, 32'h0F0F0F0F, s0);
    wait_term(lat, to);
    it = sb_q.pop_front();
    n_checks++; if (to || lat !== 3 || wb_ack_o !== !it.exp_err) begin n_errors++; $display("FAIL ab_next: got ack %b lat %0d exp %b lat 3", wb_ack_o, lat, !it.exp_err); end
    n_checks++; if (wb_dat_o !== it.exp_dat) begin n_errors++; $display("FAIL ab_next_data: got %h exp %h", wb_dat_o, it.exp_dat); end
    wb_idle(); tick();
  endtask

  task automatic test_reset_mid();
    int unsigned s0, lat; bit to, found; sb_t it;
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 6; cfg_bresp = 2'b00;
    wb_start(1, 32'h300, 32'h33333333, 4'hF, 0, 32'h0, s0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (m_axi_bready) found = 1;
    end
    n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL rm_reach_wr_resp: got bready never, exp within 10 cycles"); end
    rst_i = 1; wb_idle();
    it = sb_q.pop_front();
    tick();
    n_checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin n_errors++; $display("FAIL rm_valids: got %b exp 00000", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}); end
    n_checks++; if ({wb_ack_o, wb_err_o} !== 2'b00 || wb_dat_o !== 32'h0) begin n_errors++; $display("FAIL rm_wb: got ack/err %b dat %h exp 00 0", {wb_ack_o, wb_err_o}, wb_dat_o); end
    rst_i = 0; cfg_b_dly = 0;
    tick();
    wb_start(1, 32'h304, 32'h44444444, 4'h5, 0, 32'h0, s0);
    wait_term(lat, to);
    it = sb_q.pop_front();
    n_checks++; if (to || lat !== 3 || wb_ack_o !== !it.exp_err) begin n_errors++; $display("FAIL rm_after: got ack %b lat %0d exp %b lat 3", wb_ack_o, lat, !it.exp_err); end
    n_checks++; if ({seen_awaddr, seen_wdata, seen_wstrb} !== {it.adr, it.wdat, it.sel}) begin n_errors++; $display("FAIL rm_payload: got %h %h %h exp %h %h %h", seen_awaddr, seen_wdata, seen_wstrb, it.adr, it.wdat, it.sel); end
    wb_idle(); tick();
  endtask

  task automatic test_back_to_back();
    int unsigned s0, lat, t1; bit to; sb_t it;
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 32'h22222222;
    wb_start(1, 32'h200, 32'h11111111, 4'h0, 0, 32'h0, s0);
    wait_term(lat, to);
    it = sb_q.pop_front();
    t1 = cycle_no;
    n_checks++; if (to || wb_ack_o !== !it.exp_err || lat !== 3) begin n_errors++; $display("FAIL bb_first: got ack %b lat %0d exp %b lat 3", wb_ack_o, lat, !it.exp_err); end
    n_checks++; if (seen_wstrb !== it.sel || seen_awaddr !== it.adr) begin n_errors++; $display("FAIL bb_sel0: got wstrb %h addr %h exp %h %h", seen_wstrb, seen_awaddr, it.sel, it.adr); end
    tick();
    n_checks++; if ({wb_ack_o, wb_err_o} !== 2'b00) begin n_errors++; $display("FAIL bb_gap: got %b exp 00", {wb_ack_o, wb_err_o}); end
    wb_start(0, 32'h204, 32'h0, 4'hF, 0, 32'h22222222, s0);
    wait_term(lat, to);
    it = sb_q.pop_front();
    n_checks++; if (to || cycle_no - t1 !== 4 || wb_ack_o !== !it.exp_err) begin n_errors++; $display("FAIL bb_rate: got spacing %0d ack %b exp 4 %b", cycle_no - t1, wb_ack_o, !it.exp_err); end
    n_checks++; if (wb_dat_o !== it.exp_dat) begin n_errors++; $display("FAIL bb_data: got %h exp %h", wb_dat_o, it.exp_dat); end
    wb_idle(); tick();
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_write_skewed();
    test_read();
    test_error();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    n_checks++; if (sb_q.size() !== 0) begin n_errors++; $display("FAIL sb_leftover: got %0d entries exp 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
